stack_sequencer: RTL and testbench

- Controls the 16-bit data-memory port of the execute-memory stage for all stack traffic.
- Handles single-word PUSH/POP in one cycle.
- Breaks multi-word CALL/RET/INT/RTI into one memory access per cycle, and stalls the pipeline until the last access.
- Owns the stack pointer; delivers the popped PC and popped flags word back to the stage.

---
 rtl/stack_pkg.sv | 33 +++
 rtl/stack_pointer.sv | 32 +++
 rtl/stack_sequencer.sv | 179 +++++++++++++++++
 tb/tb_stack_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared command/state encodings and flag layout for the stack sequencer
package stack_pkg;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_PUSH = 3'd1;
  localparam logic [2:0] CMD_POP  = 3'd2;
  localparam logic [2:0] CMD_CALL = 3'd3;
  localparam logic [2:0] CMD_RET  = 3'd4;
  localparam logic [2:0] CMD_INT  = 3'd5;
  localparam logic [2:0] CMD_RTI  = 3'd6;

  localparam int FLAG_Z = 15;
  localparam int FLAG_N = 14;
  localparam int FLAG_C = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_PC_LO,
    ST_PUSH_FLAGS,
    ST_POP_PC_LO,
    ST_POP_PC_HI
  } state_e;

  function automatic logic [15:0] flags_word(input logic [2:0] znc);
    logic [15:0] w;
    w = '0;
    w[FLAG_Z] = znc[2];
    w[FLAG_N] = znc[1];
    w[FLAG_C] = znc[0];
    return w;
  endfunction

endpackage

// File: rtl/stack_pointer.sv
// rtl/stack_pointer.sv - stack pointer register with inc/dec and SP/SP+1 address outputs
module stack_pointer
  import stack_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_RESET = 16'h07FF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [ADDR_W-1:0] o_sp,
  output logic [ADDR_W-1:0] o_sp_plus1
);

  logic [ADDR_W-1:0] sp_q, sp_d;

  always_comb begin
    sp_d = sp_q;
    if (i_inc)      sp_d = sp_q + ADDR_W'(1);
    else if (i_dec) sp_d = sp_q - ADDR_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) sp_q <= SP_RESET;
    else         sp_q <= sp_d;
  end

  assign o_sp       = sp_q;
  assign o_sp_plus1 = sp_q + ADDR_W'(1);

endmodule

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - sequences single- and multi-word stack traffic onto the data-memory port
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_RESET = 16'h07FF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [2:0]        i_cmd,
  input  logic [15:0]       i_data,
  input  logic [31:0]       i_pc,
  input  logic [2:0]        i_flags,
  input  logic [15:0]       i_mem_read_data,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [15:0]       o_mem_write_data,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_stall,
  output logic [15:0]       o_pop_data,
  output logic              o_pop_valid,
  output logic [31:0]       o_pc_new,
  output logic              o_pc_valid,
  output logic [2:0]        o_flags,
  output logic              o_flags_valid,
  output logic [ADDR_W-1:0] o_sp
);

  state_e      state_q, state_d;
  logic [15:0] pc_lo_q, pc_lo_d;
  logic [15:0] push_pc_lo_q, push_pc_lo_d;
  logic [2:0]  flags_q, flags_d;
  logic        is_int_q, is_int_d;
  logic        sp_inc, sp_dec;
  logic [ADDR_W-1:0] sp, sp_plus1;

  stack_pointer #(.ADDR_W(ADDR_W), .SP_RESET(SP_RESET)) u_sp (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_inc      (sp_inc),
    .i_dec      (sp_dec),
    .o_sp       (sp),
    .o_sp_plus1 (sp_plus1)
  );

  assign o_sp = sp;

  always_comb begin
    state_d          = state_q;
    pc_lo_d          = pc_lo_q;
    push_pc_lo_d     = push_pc_lo_q;
    flags_d          = flags_q;
    is_int_d         = is_int_q;
    sp_inc           = 1'b0;
    sp_dec           = 1'b0;
    o_mem_address    = sp;
    o_mem_write_data = '0;
    o_mem_read       = 1'b0;
    o_mem_write      = 1'b0;
    o_stall          = 1'b0;
    o_pop_data       = '0;
    o_pop_valid      = 1'b0;
    o_pc_new         = '0;
    o_pc_valid       = 1'b0;
    o_flags          = '0;
    o_flags_valid    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Later cycles of CALL/INT use only these copies, not the live inputs.
        push_pc_lo_d = i_pc[15:0];
        flags_d      = i_flags;
        case (i_cmd)
          CMD_PUSH: begin
            o_mem_write      = 1'b1;
            o_mem_write_data = i_data;
            sp_dec           = 1'b1;
          end
          CMD_POP: begin
            o_mem_read    = 1'b1;
            o_mem_address = sp_plus1;
            o_pop_valid   = 1'b1;
            o_pop_data    = i_mem_read_data;
            sp_inc        = 1'b1;
          end
          CMD_CALL, CMD_INT: begin
            o_mem_write      = 1'b1;
            o_mem_write_data = i_pc[31:16];
            sp_dec           = 1'b1;
            o_stall          = 1'b1;
            is_int_d         = (i_cmd == CMD_INT);
            state_d          = ST_PUSH_PC_LO;
          end
          CMD_RET: begin
            o_mem_read    = 1'b1;
            o_mem_address = sp_plus1;
            pc_lo_d       = i_mem_read_data;
            sp_inc        = 1'b1;
            o_stall       = 1'b1;
            state_d       = ST_POP_PC_HI;
          end
          CMD_RTI: begin
            o_mem_read    = 1'b1;
            o_mem_address = sp_plus1;
            o_flags_valid = 1'b1;
            o_flags       = {i_mem_read_data[FLAG_Z], i_mem_read_data[FLAG_N], i_mem_read_data[FLAG_C]};
            sp_inc        = 1'b1;
            o_stall       = 1'b1;
            state_d       = ST_POP_PC_LO;
          end
          default: ;
        endcase
      end
      ST_PUSH_PC_LO: begin
        o_mem_write      = 1'b1;
        o_mem_write_data = push_pc_lo_q;
        sp_dec           = 1'b1;
        o_stall          = is_int_q;
        state_d          = is_int_q ? ST_PUSH_FLAGS : ST_IDLE;
      end
      ST_PUSH_FLAGS: begin
        o_mem_write      = 1'b1;
        o_mem_write_data = flags_word(flags_q);
        sp_dec           = 1'b1;
        state_d          = ST_IDLE;
      end
      ST_POP_PC_LO: begin
        o_mem_read    = 1'b1;
        o_mem_address = sp_plus1;
        pc_lo_d       = i_mem_read_data;
        sp_inc        = 1'b1;
        o_stall       = 1'b1;
        state_d       = ST_POP_PC_HI;
      end
      ST_POP_PC_HI: begin
        o_mem_read    = 1'b1;
        o_mem_address = sp_plus1;
        o_pc_valid    = 1'b1;
        o_pc_new      = {i_mem_read_data, pc_lo_q};
        sp_inc        = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset suppresses every side effect in the cycle it is asserted.
    if (i_reset) begin
      sp_inc           = 1'b0;
      sp_dec           = 1'b0;
      o_mem_write_data = '0;
      o_mem_read       = 1'b0;
      o_mem_write      = 1'b0;
      o_stall          = 1'b0;
      o_pop_data       = '0;
      o_pop_valid      = 1'b0;
      o_pc_new         = '0;
      o_pc_valid       = 1'b0;
      o_flags          = '0;
      o_flags_valid    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      pc_lo_q      <= '0;
      push_pc_lo_q <= '0;
      flags_q      <= '0;
      is_int_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_lo_q      <= pc_lo_d;
      push_pc_lo_q <= push_pc_lo_d;
      flags_q      <= flags_d;
      is_int_q     <= is_int_d;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - self-checking bench for stack_sequencer against a word-stack reference model
module tb_stack_sequencer;
  import stack_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  cmd;
  logic [15:0] data;
  logic [31:0] pc;
  logic [2:0]  fl;

  logic [15:0] rd1, addr1, wd1, popd1, sp1;
  logic        re1, we1, stall1, popv1, pcv1, flv1;
  logic [31:0] pcn1;
  logic [2:0]  fo1;

  logic [15:0] rd2, addr2, wd2, popd2, sp2;
  logic        re2, we2, stall2, popv2, pcv2, flv2;
  logic [31:0] pcn2;
  logic [2:0]  fo2;

  logic [15:0] mem1    [0:65535];
  logic [15:0] mem2    [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] ref_sp;

  int checks = 0;
  int failures = 0;

  stack_sequencer #(.ADDR_W(16), .SP_RESET(16'h07FF)) dut (
    .i_clk(clk), .i_reset(rst), .i_cmd(cmd), .i_data(data), .i_pc(pc), .i_flags(fl),
    .i_mem_read_data(rd1), .o_mem_address(addr1), .o_mem_write_data(wd1),
    .o_mem_read(re1), .o_mem_write(we1), .o_stall(stall1),
    .o_pop_data(popd1), .o_pop_valid(popv1), .o_pc_new(pcn1), .o_pc_valid(pcv1),
    .o_flags(fo1), .o_flags_valid(flv1), .o_sp(sp1)
  );

  stack_sequencer #(.ADDR_W(16), .SP_RESET(16'h0000)) dut_wrap (
    .i_clk(clk), .i_reset(rst), .i_cmd(cmd), .i_data(data), .i_pc(pc), .i_flags(fl),
    .i_mem_read_data(rd2), .o_mem_address(addr2), .o_mem_write_data(wd2),
    .o_mem_read(re2), .o_mem_write(we2), .o_stall(stall2),
    .o_pop_data(popd2), .o_pop_valid(popv2), .o_pc_new(pcn2), .o_pc_valid(pcv2),
    .o_flags(fo2), .o_flags_valid(flv2), .o_sp(sp2)
  );

  assign rd1 = mem1[addr1];
  assign rd2 = mem2[addr2];

  always @(posedge clk) begin
    if (we1) mem1[addr1] <= wd1;
    if (we2) mem2[addr2] <= wd2;
  end

  typedef struct packed {
    logic        we;
    logic        re;
    logic        stall;
    logic        popv;
    logic        pcv;
    logic        flv;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] popd;
    logic [31:0] pc;
    logic [2:0]  fl;
  } step_t;

  typedef struct {
    logic [2:0]  cmd;
    logic [15:0] data;
    logic [31:0] pc;
    logic [2:0]  fl;
    logic [15:0] exp_sp;
    logic [31:0] exp_res;
    logic [2:0]  exp_fl;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a command is a list of words pushed (one per cycle) or a count of words popped.
  task automatic run_cmd(input logic [2:0] c, input logic [15:0] d, input logic [31:0] p,
                         input logic [2:0] f, output logic [31:0] res, output logic [2:0] rfl);
    step_t       q[$];
    step_t       s;
    logic [15:0] pw[$];
    logic [15:0] pr[$];
    int          npop;
    res  = '0;
    rfl  = '0;
    npop = 0;
    case (c)
      CMD_PUSH: pw.push_back(d);
      CMD_CALL: begin pw.push_back(p[31:16]); pw.push_back(p[15:0]); end
      CMD_INT:  begin pw.push_back(p[31:16]); pw.push_back(p[15:0]); pw.push_back({f, 13'b0}); end
      CMD_POP:  npop = 1;
      CMD_RET:  npop = 2;
      CMD_RTI:  npop = 3;
      default: ;
    endcase
    foreach (pw[i]) begin
      s = '0;
      s.we = 1'b1;
      s.addr = ref_sp;
      s.wdata = pw[i];
      s.stall = (i != pw.size() - 1);
      ref_mem[ref_sp] = pw[i];
      ref_sp = ref_sp - 16'd1;
      q.push_back(s);
    end
    for (int i = 0; i < npop; i++) begin
      ref_sp = ref_sp + 16'd1;
      s = '0;
      s.re = 1'b1;
      s.addr = ref_sp;
      s.stall = (i != npop - 1);
      pr.push_back(ref_mem[ref_sp]);
      q.push_back(s);
    end
    if (c == CMD_POP) begin q[0].popv = 1'b1; q[0].popd = pr[0]; end
    if (c == CMD_RET) begin q[1].pcv = 1'b1; q[1].pc = {pr[1], pr[0]}; end
    if (c == CMD_RTI) begin
      q[0].flv = 1'b1; q[0].fl = pr[0][15:13];
      q[2].pcv = 1'b1; q[2].pc = {pr[2], pr[1]};
    end
    if (q.size() == 0) begin
      s = '0;
      s.addr = ref_sp;
      q.push_back(s);
    end

    cmd = c; data = d; pc = p; fl = f;
    foreach (q[k]) begin
      @(negedge clk);
      chk("ctrl{we,re,stall,popv,pcv,flv}", {26'b0, we1, re1, stall1, popv1, pcv1, flv1},
          {26'b0, q[k].we, q[k].re, q[k].stall, q[k].popv, q[k].pcv, q[k].flv});
      chk("mem_address", {16'b0, addr1}, {16'b0, q[k].addr});
      if (q[k].we) chk("mem_write_data", {16'b0, wd1}, {16'b0, q[k].wdata});
      if (q[k].popv) begin chk("pop_data", {16'b0, popd1}, {16'b0, q[k].popd}); res = {16'b0, popd1}; end
      if (q[k].pcv) begin chk("pc_new", pcn1, q[k].pc); res = pcn1; end
      if (q[k].flv) begin chk("flags", {29'b0, fo1}, {29'b0, q[k].fl}); rfl = fo1; end
      @(posedge clk);
      #1;
      data = 16'($urandom);
      pc   = $urandom;
      fl   = 3'($urandom);
    end
    cmd = CMD_NOP;
    chk("sp_after_cmd", {16'b0, sp1}, {16'b0, ref_sp});
  endtask

  vec_t        tbl [6];
  logic [31:0] res;
  logic [2:0]  rfl;
  logic [15:0] saved;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem1[i] = '0; mem2[i] = '0; ref_mem[i] = '0;
    end
    ref_sp = 16'h07FF;
    rst = 1'b1; cmd = CMD_CALL; data = 16'h1111; pc = 32'h2222_3333; fl = 3'b111;

    // Reset cycle must suppress the command on i_cmd.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {26'b0, we1, re1, stall1, popv1, pcv1, flv1}, 32'h0);
    chk("reset_wdata", {16'b0, wd1}, 32'h0);
    chk("reset_pc_new", pcn1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; cmd = CMD_NOP;
    @(negedge clk);
    chk("idle_sp", {16'b0, sp1}, 32'h07FF);
    chk("idle_addr", {16'b0, addr1}, 32'h07FF);
    chk("idle_ctrl", {26'b0, we1, re1, stall1, popv1, pcv1, flv1}, 32'h0);
    chk("wrap_reset_sp", {16'b0, sp2}, 32'h0000);
    @(posedge clk); #1;

    // SP wrap on the SP_RESET=0 instance.
    cmd = CMD_PUSH; data = 16'h5A5A;
    @(negedge clk);
    chk("wrap_push_addr", {16'b0, addr2}, 32'h0000);
    chk("wrap_push_we", {31'b0, we2}, 32'h1);
    @(posedge clk); #1;
    chk("wrap_sp_dec", {16'b0, sp2}, 32'hFFFF);
    cmd = CMD_POP;
    @(negedge clk);
    chk("wrap_pop_addr", {16'b0, addr2}, 32'h0000);
    chk("wrap_pop_data", {16'b0, popd2}, 32'h5A5A);
    @(posedge clk); #1;
    chk("wrap_sp_inc", {16'b0, sp2}, 32'h0000);
    cmd = CMD_NOP;
    ref_mem[16'h07FF] = 16'h5A5A;

    tbl[0] = '{CMD_PUSH, 16'hABCD, 32'h0,          3'b000, 16'h07FE, 32'h0,          3'b000};
    tbl[1] = '{CMD_POP,  16'h0,    32'h0,          3'b000, 16'h07FF, 32'h0000_ABCD,  3'b000};
    tbl[2] = '{CMD_CALL, 16'h0,    32'h0001_2345,  3'b000, 16'h07FD, 32'h0,          3'b000};
    tbl[3] = '{CMD_RET,  16'h0,    32'h0,          3'b000, 16'h07FF, 32'h0001_2345,  3'b000};
    tbl[4] = '{CMD_INT,  16'h0,    32'h0000_0100,  3'b101, 16'h07FC, 32'h0,          3'b000};
    tbl[5] = '{CMD_RTI,  16'h0,    32'h0,          3'b000, 16'h07FF, 32'h0000_0100,  3'b101};
    for (int i = 0; i < 6; i++) begin
      run_cmd(tbl[i].cmd, tbl[i].data, tbl[i].pc, tbl[i].fl, res, rfl);
      chk("tbl_sp", {16'b0, sp1}, {16'b0, tbl[i].exp_sp});
      if (tbl[i].cmd inside {CMD_POP, CMD_RET, CMD_RTI}) chk("tbl_result", res, tbl[i].exp_res);
      if (tbl[i].cmd == CMD_RTI) chk("tbl_flags", {29'b0, rfl}, {29'b0, tbl[i].exp_fl});
    end
    chk("int_word0", {16'b0, mem1[16'h07FF]}, 32'h0000);
    chk("int_word1", {16'b0, mem1[16'h07FE]}, 32'h0100);
    chk("int_word2", {16'b0, mem1[16'h07FD]}, 32'hA000);

    // Reset in the second cycle of INT aborts it without a write.
    saved = mem1[16'h07FE];
    cmd = CMD_INT; pc = 32'hBEEF_1234; fl = 3'b011;
    @(negedge clk);
    chk("int_abort_c0", {29'b0, we1, stall1, 1'b0}, 32'b110);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("int_abort_reset_ctrl", {26'b0, we1, re1, stall1, popv1, pcv1, flv1}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; cmd = CMD_NOP;
    @(negedge clk);
    chk("int_abort_sp", {16'b0, sp1}, 32'h07FF);
    chk("int_abort_idle", {16'b0, addr1, 13'b0, we1, re1, stall1}, {16'b0, 16'h07FF, 16'h0});
    chk("int_abort_nowrite", {16'b0, mem1[16'h07FE]}, {16'b0, saved});
    @(posedge clk); #1;
    ref_mem[16'h07FF] = 16'hBEEF;
    ref_sp = 16'h07FF;

    for (int n = 0; n < 300; n++) begin
      run_cmd(3'($urandom_range(0, 7)), 16'($urandom), $urandom, 3'($urandom), res, rfl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
